// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL reset, qualifies lock, releases downstream reset, tracks retries/losses/fault
module pll_lock_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int MAX_RETRIES        = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count,
   output logic [7:0] loss_count
);
   localparam int CMAX0 = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int CMAX  = CMAX0 > LOCK_STABLE_CYCLES ? CMAX0 : LOCK_STABLE_CYCLES;
   localparam int CW    = CMAX > 1 ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] RST_TC = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_TC  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] ST_TC  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]    MAX_R  = 4'(MAX_RETRIES);
   typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    retry_q, retry_d;
   logic [7:0]    loss_q, loss_d;
   logic          s1_q, s2_q;
   logic          pll_rst_q, sys_reset_q, ready_q, fault_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         RESET_PLL: if (cnt_q == RST_TC) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
         WAIT_LOCK: if (s2_q) begin
            state_d = STABILIZE;
            cnt_d   = '0;
         end else if (cnt_q == TO_TC) begin
            cnt_d   = '0;
            state_d = retry_q == MAX_R ? FAULT : RESET_PLL;
            retry_d = retry_q == MAX_R ? retry_q : retry_q + 4'd1;
         end
         STABILIZE: if (!s2_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end else if (cnt_q == ST_TC) begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            cnt_d = '0;
            if (!s2_q) begin
               state_d = RESET_PLL;
               retry_d = '0;
               loss_d  = loss_q == 8'hff ? loss_q : loss_q + 8'd1;
            end
         end
         FAULT: cnt_d = '0;
         default: begin
            state_d = RESET_PLL;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         s1_q        <= pll_locked;
         s2_q        <= s1_q;
         pll_rst_q   <= state_d == RESET_PLL || state_d == FAULT;
         sys_reset_q <= state_d != RUN;
         ready_q     <= state_d == RUN;
         fault_q     <= state_d == FAULT;
      end
   end
   assign pll_rst     = pll_rst_q;
   assign sys_reset   = sys_reset_q;
   assign ready       = ready_q;
   assign fault       = fault_q;
   assign retry_count = retry_q;
   assign loss_count  = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bench with edge-counted expectations (PLL_RST=4, TIMEOUT=20, STABLE=8, RETRIES=2)
module tb_pll_lock_sequencer;
   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_reset, ready, fault;
   logic [3:0] retry_count;
   logic [7:0] loss_count;
   int         checks = 0;
   int         failures = 0;
   pll_lock_sequencer #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
      .sys_reset(sys_reset), .ready(ready), .fault(fault),
      .retry_count(retry_count), .loss_count(loss_count)
   );
   always #10 refclk = ~refclk;
   task automatic step(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
      chk({tag, "_sys_reset"}, 32'(sys_reset), 1);
      chk({tag, "_ready"}, 32'(ready), 0);
      chk({tag, "_fault"}, 32'(fault), 0);
      chk({tag, "_retry"}, 32'(retry_count), 0);
      chk({tag, "_loss"}, 32'(loss_count), 0);
   endtask
   task automatic do_reset;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
   endtask
   initial begin
      // reset values and pll_rst pulse width (R = last edge sampling rst=1)
      pll_locked = 1'b0;
      do_reset();
      chk_reset_vals("rst");
      step(3);
      chk("rst_pll_rst_r3", 32'(pll_rst), 1);
      step(1);
      chk("rst_pll_rst_r4", 32'(pll_rst), 0);
      chk("rst_sys_reset_r4", 32'(sys_reset), 1);
      // clean bring-up: locked set after R+10, first sampled at R+11, release at R+21
      do_reset();
      step(10);
      pll_locked = 1'b1;
      step(10);
      chk("up_sys_reset_r20", 32'(sys_reset), 1);
      chk("up_ready_r20", 32'(ready), 0);
      step(1);
      chk("up_sys_reset_r21", 32'(sys_reset), 0);
      chk("up_ready_r21", 32'(ready), 1);
      chk("up_retry", 32'(retry_count), 0);
      chk("up_pll_rst", 32'(pll_rst), 0);
      // stability glitch: high 5, low 2, high -> release at R+28
      pll_locked = 1'b0;
      do_reset();
      step(10);
      pll_locked = 1'b1;
      step(5);
      pll_locked = 1'b0;
      step(2);
      pll_locked = 1'b1;
      step(4);
      chk("gl_sys_reset_r21", 32'(sys_reset), 1);
      chk("gl_pll_rst_r21", 32'(pll_rst), 0);
      step(6);
      chk("gl_sys_reset_r27", 32'(sys_reset), 1);
      step(1);
      chk("gl_sys_reset_r28", 32'(sys_reset), 0);
      chk("gl_ready_r28", 32'(ready), 1);
      chk("gl_retry", 32'(retry_count), 0);
      // timeout retries then fault at R+72
      pll_locked = 1'b0;
      do_reset();
      step(23);
      chk("to_retry_r23", 32'(retry_count), 0);
      chk("to_pll_rst_r23", 32'(pll_rst), 0);
      step(1);
      chk("to_retry_r24", 32'(retry_count), 1);
      chk("to_pll_rst_r24", 32'(pll_rst), 1);
      step(3);
      chk("to_pll_rst_r27", 32'(pll_rst), 1);
      step(1);
      chk("to_pll_rst_r28", 32'(pll_rst), 0);
      step(20);
      chk("to_retry_r48", 32'(retry_count), 2);
      chk("to_pll_rst_r48", 32'(pll_rst), 1);
      step(23);
      chk("to_fault_r71", 32'(fault), 0);
      step(1);
      chk("to_fault_r72", 32'(fault), 1);
      chk("to_pll_rst_r72", 32'(pll_rst), 1);
      chk("to_sys_reset_r72", 32'(sys_reset), 1);
      chk("to_retry_r72", 32'(retry_count), 2);
      pll_locked = 1'b1;
      step(20);
      chk("to_fault_sticky", 32'(fault), 1);
      chk("to_ready_sticky", 32'(ready), 0);
      // reset while in FAULT
      rst = 1'b1;
      step(1);
      chk_reset_vals("rstf");
      rst = 1'b0;
      pll_locked = 1'b0;
      step(4);
      chk("rstf_restart_pll_rst", 32'(pll_rst), 0);
      // reset while in STABILIZE at counter 5 (locked high from release: STABILIZE at R+5)
      pll_locked = 1'b1;
      do_reset();
      step(10);
      chk("st_sys_reset_r10", 32'(sys_reset), 1);
      rst = 1'b1;
      step(1);
      chk_reset_vals("rsts");
      rst = 1'b0;
      // lock loss in RUN: restart gives RUN at R+13
      step(12);
      chk("ll_sys_reset_r12", 32'(sys_reset), 1);
      step(1);
      chk("ll_ready_r13", 32'(ready), 1);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(1);
      chk("ll_sys_reset_r15", 32'(sys_reset), 0);
      step(1);
      chk("ll_sys_reset_r16", 32'(sys_reset), 1);
      chk("ll_ready_r16", 32'(ready), 0);
      chk("ll_pll_rst_r16", 32'(pll_rst), 1);
      chk("ll_loss_r16", 32'(loss_count), 1);
      chk("ll_retry_r16", 32'(retry_count), 0);
      step(3);
      chk("ll_pll_rst_r19", 32'(pll_rst), 1);
      step(1);
      chk("ll_pll_rst_r20", 32'(pll_rst), 0);
      step(8);
      chk("ll_sys_reset_r28", 32'(sys_reset), 1);
      step(1);
      chk("ll_sys_reset_r29", 32'(sys_reset), 0);
      chk("ll_ready_r29", 32'(ready), 1);
      chk("ll_loss_r29", 32'(loss_count), 1);
      // each loss round trip takes 16 edges from RUN back to RUN
      for (int i = 0; i < 253; i++) begin
         pll_locked = 1'b0;
         step(1);
         pll_locked = 1'b1;
         step(15);
      end
      chk("ll_loss_254", 32'(loss_count), 254);
      chk("ll_ready_254", 32'(ready), 1);
      for (int i = 0; i < 46; i++) begin
         pll_locked = 1'b0;
         step(1);
         pll_locked = 1'b1;
         step(15);
      end
      chk("ll_loss_sat", 32'(loss_count), 255);
      chk("ll_ready_sat", 32'(ready), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sits on the reference-clock side of the audio/video clock PLL.
- Drives the PLL reset, waits for the PLL `locked` indication, qualifies it for stability, then releases a synchronous reset to the downstream audio/video logic.
- On loss of lock it re-sequences the PLL and counts the event. After repeated lock timeouts it latches a fault.
- Runs on the free-running 50 MHz reference clock, never on PLL outputs.

Parameters:
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before the attempt is declared failed (≥2).
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before release (≥1).
- MAX_RETRIES, 3: failed lock attempts tolerated before FAULT (0..15).

Ports:
- refclk  in  1  reference clock, 50 MHz, free-running.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked flag, asynchronous to refclk.
- pll_rst  out  1  PLL reset, active high.
- sys_reset  out  1  downstream synchronous reset, active high.
- ready  out  1  high while clocks are qualified (state RUN).
- fault  out  1  high in FAULT; sticky until rst.
- retry_count  out  4  failed lock attempts in the current bring-up.
- loss_count  out  8  lock losses seen in RUN; saturates at 255.

Behaviour:
- pll_locked passes through a 2-flop synchronizer (s1→s2). All decisions use s2. Glitches shorter than one refclk period may be missed; this is acceptable.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- rst high: state=RESET_PLL, counter=0, synchronizer=0, pll_rst=1, sys_reset=1, ready=0, fault=0, retry_count=0, loss_count=0. rst dominates every other event.
- State RESET_PLL: pll_rst=1, sys_reset=1.
  - Counter counts 0..PLL_RST_CYCLES-1.
  - At terminal count → WAIT_LOCK with counter=0.
  - Lasts exactly PLL_RST_CYCLES cycles.
- State WAIT_LOCK: pll_rst=0, sys_reset=1.
  - s2=1 → STABILIZE with counter=0. This check has priority over timeout.
  - Otherwise, counter==LOCK_TIMEOUT-1:
    - If retry_count==MAX_RETRIES → FAULT.
    - Else retry_count+1 → RESET_PLL with counter=0.
  - Otherwise counter+1.
- State STABILIZE: pll_rst=0, sys_reset=1.
  - s2=0 → WAIT_LOCK with counter=0. The timeout restarts and retry_count is unchanged.
  - s2=1 and counter==LOCK_STABLE_CYCLES-1 → RUN.
  - Otherwise counter+1.
- State RUN: pll_rst=0, sys_reset=0, ready=1.
  - s2=0 → RESET_PLL with counter=0, retry_count=0, and loss_count+1 (saturating at 255).
  - sys_reset reasserts and ready drops on that same edge.
- State FAULT: pll_rst=1, sys_reset=1, ready=0, fault=1. Exited only by rst.
- Release latency: pll_locked high and stable before edge E, with the FSM in WAIT_LOCK.
  - Edge E+1: s2=1.
  - Edge E+2: enter STABILIZE.
  - Edge E+2+LOCK_STABLE_CYCLES: enter RUN; sys_reset=0.
- Lock loss latency: pll_locked falling before edge E → RESET_PLL and sys_reset=1 at edge E+2.
- FAULT timing with pll_locked never high: (MAX_RETRIES+1)·(PLL_RST_CYCLES+LOCK_TIMEOUT) cycles after rst deasserts.
- Counter is wide enough for max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES) and never wraps.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2 unless stated.
- Reset values: hold rst 3 cycles, then release with pll_locked=0 → pll_rst=1 for exactly 4 cycles then 0; sys_reset=1, ready=0, fault=0, both counts 0.
- Clean bring-up: pll_locked rises 10 cycles after rst release and stays high → sys_reset falls and ready rises 10 edges after the first edge sampling pll_locked=1; retry_count=0.
- Stability glitch: pll_locked high 5 cycles, low 2, then high → no release during the glitch; state returns to WAIT_LOCK; release occurs 10 edges after the final rise; retry_count=0.
- Timeout retry/fault: pll_locked held 0 → retry_count steps 1 and 2, pll_rst pulses 3 times (4 cycles each); fault=1 exactly 72 cycles after rst release and stays there; pll_locked=1 afterwards has no effect until rst.
- Lock loss in RUN: reach RUN, drop pll_locked for 1 cycle → sys_reset=1 two edges later, loss_count=1, pll_rst pulses 4 cycles; re-lock gives a second release. Force 300 losses → loss_count=255.
- Reset mid-operation: assert rst while in STABILIZE (counter=5) and in FAULT → next edge shows the full reset values listed above; the sequence restarts from RESET_PLL.
